// File: rtl/hist_eq_pkg.sv
// Shared types and default-derived constants for the histogram-equalisation engine.
package hist_eq_pkg;

  localparam int unsigned PIX_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 17;
  localparam int unsigned NBINS     = 2 ** PIX_W_DEF;
  localparam int unsigned PROD_W    = CNT_W_DEF + PIX_W_DEF;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  typedef enum logic [2:0] {
    StIdle,
    StAcc,
    StNorm,
    StRd,
    StWait,
    StLook,
    StWr,
    StDone
  } state_e;

endpackage

// File: rtl/hist_eq_engine_seq_divider.sv
// Restoring divider: one quotient bit per cycle, go pulse in, rdy pulse out with quotient.
module seq_divider #(
  parameter int unsigned DVD_W = 25,
  parameter int unsigned DVS_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             rdy,
  output logic [DVD_W-1:0] quotient
);

  localparam int unsigned CntW = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] rem_q, dvs_q;
  logic [DVD_W-1:0] quo_q;
  logic [CntW-1:0]  cnt_q;
  logic             rdy_q;
  logic [DVS_W:0]   shifted, diff;

  // Partial remainder with the next dividend bit shifted in, and trial subtraction.
  always_comb begin
    shifted = {rem_q, quo_q[DVD_W-1]};
    diff    = shifted - {1'b0, dvs_q};
  end

  // Iteration state; the quotient builds up in place of the consumed dividend bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
    end else if (go) begin
      rem_q <= '0;
      dvs_q <= divisor;
      quo_q <= dividend;
      cnt_q <= CntW'(DVD_W);
      rdy_q <= 1'b0;
    end else if (cnt_q != '0) begin
      if (shifted >= {1'b0, dvs_q}) begin
        rem_q <= DVS_W'(diff);
        quo_q <= {quo_q[DVD_W-2:0], 1'b1};
      end else begin
        rem_q <= DVS_W'(shifted);
        quo_q <= {quo_q[DVD_W-2:0], 1'b0};
      end
      cnt_q <= cnt_q - 1'b1;
      rdy_q <= (cnt_q == CntW'(1));
    end else begin
      rdy_q <= 1'b0;
    end
  end

  assign rdy      = rdy_q;
  assign quotient = quo_q;

endmodule

// File: rtl/hist_eq_engine.sv
// Histogram equalisation: accumulate CDF, normalise into a LUT, remap a BRAM region.
// Optional macro HEQ_CLIP_EN clips each bin count to CLIP_LIMIT before accumulation.
module hist_eq_engine
  import hist_eq_pkg::*;
#(
  parameter int unsigned PIX_W      = PIX_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned NPIX       = 60136,
  parameter int unsigned SRC_BASE   = 0,
  parameter int unsigned DST_BASE   = 60136,
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned CLIP_LIMIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hist_valid,
  input  logic [CNT_W-1:0]  hist_cnt,
  output logic              hist_ready,
  output logic              busy,
  output logic              done,
  output logic              ren,
  output logic              wen,
  output logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  din,
  input  logic [PIX_W-1:0]  dout
);

  localparam int unsigned NumBins = 2 ** PIX_W;
  localparam int unsigned ProdW   = CNT_W + PIX_W;

`ifdef HEQ_CLIP_EN
  localparam bit ClipEn = 1'b1;
`else
  localparam bit ClipEn = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [PIX_W-1:0] bin_q;
  logic [CNT_W-1:0] cdf_acc_q, cdf_min_q, total_q, idx_q;
  logic             min_found_q, div_pend_q;
  logic [PIX_W-1:0] pixel_q;
  logic [7:0]       wait_q;
  logic [CNT_W-1:0] lut_q [NumBins];

  logic [CNT_W-1:0] cnt_in, cdf_new, cdf_cur;
  logic             identity, below, norm_step, div_go, div_rdy;
  logic [ProdW-1:0] div_quo;

  // Clipped count, running CDF and normalisation predicates.
  always_comb begin
    cnt_in   = (ClipEn && (hist_cnt > CNT_W'(CLIP_LIMIT))) ? CNT_W'(CLIP_LIMIT) : hist_cnt;
    cdf_new  = cdf_acc_q + cnt_in;
    cdf_cur  = lut_q[bin_q];
    identity = (total_q == cdf_min_q);
    below    = (cdf_cur < cdf_min_q);
  end

  seq_divider #(
    .DVD_W(ProdW),
    .DVS_W(CNT_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (div_go),
    .dividend(ProdW'(cdf_cur - cdf_min_q) * ProdW'(NumBins - 1)),
    .divisor (total_q - cdf_min_q),
    .rdy     (div_rdy),
    .quotient(div_quo)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic and BRAM/handshake outputs.
  always_comb begin
    state_d    = state_q;
    hist_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    ren        = 1'b0;
    wen        = 1'b0;
    addr       = '0;
    din        = '0;
    div_go     = 1'b0;
    norm_step  = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) state_d = StAcc;
      end
      StAcc: begin
        hist_ready = 1'b1;
        if (hist_valid && (&bin_q)) state_d = StNorm;
      end
      StNorm: begin
        norm_step = identity || below || div_rdy;
        div_go    = !identity && !below && !div_pend_q;
        if (norm_step && (&bin_q)) state_d = StRd;
      end
      StRd: begin
        ren     = 1'b1;
        addr    = ADDR_W'(SRC_BASE) + ADDR_W'(idx_q);
        state_d = (READ_LAT == 0) ? StLook : StWait;
      end
      StWait: begin
        if (wait_q == 8'(READ_LAT - 1)) state_d = StLook;
      end
      StLook: state_d = StWr;
      StWr: begin
        wen     = 1'b1;
        addr    = ADDR_W'(DST_BASE) + ADDR_W'(idx_q);
        din     = PIX_W'(lut_q[pixel_q]);
        state_d = (idx_q == CNT_W'(NPIX - 1)) ? StDone : StRd;
      end
      StDone: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Accumulator, counters and per-pixel capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q       <= '0;
      cdf_acc_q   <= '0;
      cdf_min_q   <= '0;
      total_q     <= '0;
      idx_q       <= '0;
      min_found_q <= 1'b0;
      div_pend_q  <= 1'b0;
      pixel_q     <= '0;
      wait_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            bin_q       <= '0;
            cdf_acc_q   <= '0;
            cdf_min_q   <= '0;
            idx_q       <= '0;
            min_found_q <= 1'b0;
            div_pend_q  <= 1'b0;
          end
        end
        StAcc: begin
          if (hist_valid) begin
            cdf_acc_q <= cdf_new;
            bin_q     <= bin_q + 1'b1;
            if (!min_found_q && (cdf_new != '0)) begin
              cdf_min_q   <= cdf_new;
              min_found_q <= 1'b1;
            end
            if (&bin_q) total_q <= cdf_new;
          end
        end
        StNorm: begin
          if (div_go) div_pend_q <= 1'b1;
          if (norm_step) begin
            div_pend_q <= 1'b0;
            bin_q      <= bin_q + 1'b1;
          end
        end
        StRd:   wait_q  <= '0;
        StWait: wait_q  <= wait_q + 1'b1;
        StLook: pixel_q <= dout;
        StWr:   idx_q   <= idx_q + 1'b1;
        default: ;
      endcase
    end
  end

  // LUT holds the raw CDF after ACC and is overwritten in place with remap values in NORM.
  always_ff @(posedge clk) begin
    if (state_q == StAcc && hist_valid) begin
      lut_q[bin_q] <= cdf_new;
    end else if (state_q == StNorm && norm_step) begin
      if (identity)   lut_q[bin_q] <= CNT_W'(bin_q);
      else if (below) lut_q[bin_q] <= '0;
      else            lut_q[bin_q] <= CNT_W'(div_quo);
    end
  end

endmodule

// File: doc/hist_eq_engine.md
# hist_eq_engine

Parametrised histogram-equalisation engine. It accepts a streamed intensity histogram and builds the CDF one bin per cycle. It then normalises the CDF into a remap LUT with a sequential divider, and remaps a whole image region in the shared BRAM (read source pixel, look up, write destination pixel). It replaces the single-cycle combinational CDF/normalise stage; it sits between the histogram counter and the tile/output stage.

## Interface
Parameters:
- `PIX_W`, 8: pixel width; `NBINS = 2**PIX_W`.
- `CNT_W`, 17: histogram count and CDF width; must satisfy `2**CNT_W > NPIX`.
- `ADDR_W`, 17: BRAM address width.
- `NPIX`, 60136: pixels per frame.
- `SRC_BASE`, 0: first source pixel address.
- `DST_BASE`, 60136: first destination pixel address.
- `READ_LAT`, 2: BRAM read latency in cycles.
- `CLIP_LIMIT`, 255: per-bin clip ceiling. Used only with `HEQ_CLIP_EN`.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: one-cycle request. Sampled only in IDLE.
- `hist_valid`, in, 1: histogram bin count valid.
- `hist_cnt`, in, CNT_W: bin count, bins presented in order 0..NBINS-1.
- `hist_ready`, out, 1: engine accepts a bin this cycle.
- `busy`, out, 1: high from the start acceptance until done.
- `done`, out, 1: one-cycle pulse at frame completion.
- `ren`, out, 1: BRAM read enable.
- `wen`, out, 1: BRAM write enable.
- `addr`, out, ADDR_W: BRAM address.
- `din`, out, PIX_W: BRAM write data.
- `dout`, in, PIX_W: BRAM read data.

## Operation
State machine: IDLE, ACC, NORM, RD, WAIT, LOOK, WR, DONE.
- **IDLE**
  - Outputs are idle.
  - `start`=1 goes to ACC; clears `cdf_acc`, `cdf_min`, and the bin counter.
- **ACC**
  - `hist_ready`=1.
  - On each `hist_valid & hist_ready` handshake:
    - `cdf_acc += hist_cnt`.
    - `lut[bin] <= cdf_acc + hist_cnt`, stored as the raw CDF.
    - The first bin whose new CDF is nonzero latches `cdf_min`.
  - Stalls while `hist_valid`=0.
  - After bin NBINS-1, `total = cdf_acc` and the state goes to NORM.
- **NORM**, for bin = 0..NBINS-1:
  - If `cdf < cdf_min`, then `lut = 0`.
  - Otherwise `lut = ((cdf - cdf_min) * (NBINS-1)) / (total - cdf_min)`.
    - Product width is CNT_W+PIX_W.
    - Quotient is truncated (floor) and is guaranteed to be ≤ NBINS-1.
  - If `total == cdf_min` (single-valued image), the LUT becomes the identity `lut[b] = b`; no divide is started.
- **Remap**, for i = 0..NPIX-1:
  - RD: `ren`=1, `addr = SRC_BASE+i`.
  - WAIT: READ_LAT cycles.
  - LOOK: `dout` is captured and the LUT is read.
  - WR: `wen`=1, `addr = DST_BASE+i`, `din = lut[pixel]`.
  - After the last pixel the state goes to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then the state returns to IDLE.
- `ren` and `wen` are never high in the same cycle.

Boundary conditions:
- `start` while `busy` is ignored.
- `hist_valid` outside ACC is ignored.
- An all-zero histogram gives `total` = 0 = `cdf_min`, so the identity LUT is used.
- Address arithmetic wraps modulo `2**ADDR_W`.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State is IDLE.
  - `hist_ready`, `busy`, `done`, `ren`, `wen`, `addr`, and `din` are all 0.
  - LUT contents are don't-care.
- Reset asserted mid-frame aborts immediately and no further BRAM writes occur.
- Latency:
  - `busy` rises one cycle after `start`.
  - ACC takes NBINS cycles with `hist_valid` continuous.
  - NORM takes NBINS×(CNT_W+PIX_W+2) cycles worst case, or NBINS cycles on the identity path.
  - Remap takes NPIX×(READ_LAT+3) cycles, which is 5 cycles per pixel at the default READ_LAT.
- `done` and the deassertion of `busy` occur in the same cycle.

## Configuration
- `HEQ_CLIP_EN` defined:
  - Each `hist_cnt` is replaced by `min(hist_cnt, CLIP_LIMIT)` before accumulation.
  - The excess is discarded, not redistributed.
  - `total` and `cdf_min` are computed from the clipped counts.
- `HEQ_CLIP_EN` undefined: counts are used unmodified, and `CLIP_LIMIT` has no effect.

## Structure
- `hist_eq_pkg` holds:
  - the state enum;
  - the derived constants `NBINS` and `PROD_W = CNT_W+PIX_W`;
  - a `cnt_t` typedef.
- One sub-module, `seq_divider`:
  - restoring divider, PROD_W-bit dividend, CNT_W-bit divisor;
  - handshake is a `go` pulse, then a `rdy` pulse with the quotient;
  - one quotient bit per cycle.
- The LUT is an internal NBINS×CNT_W register array. After NORM, its entries hold PIX_W-bit values.

## Test plan
All scenarios use PIX_W=2, NPIX=8, READ_LAT=2.
- **Flat histogram:** hist [2,2,2,2] → LUT [0,1,2,3]. Source pixels 3,0,1,2 produce destination pixels 3,0,1,2 at DST_BASE.
- **First-nonzero minimum:** hist [0,4,0,4] → cdf_min=4, LUT [0,0,0,3]. Source 1,3 produces destination 0,3.
- **Single-valued image:** hist [0,8,0,0] → identity LUT, no divider `go`, all destination pixels equal source.
- **Clipping:** hist [1,5,1,1], CLIP_LIMIT=3:
  - With `HEQ_CLIP_EN`: LUT [0,1,2,3].
  - Without `HEQ_CLIP_EN`: LUT [0,2,2,3].
- **Handshake and protocol:**
  - `hist_valid` gapped 1-on/1-off → identical LUT to the continuous case.
  - A second `start` during remap is ignored.
  - `ren`/`wen` are never both high.
  - Remap takes exactly 40 cycles and `done` is one cycle wide.
- **Reset mid-remap:** `rst_n` low at pixel 4 → no write occurs after reset, all outputs are 0, and a new `start` runs a full frame correctly.
